// File: rtl/ekf_pkg.sv
// rtl/ekf_pkg.sv - shared types and constants for the EKF sample sequencer
package ekf_pkg;

  localparam int EKF_DATA_W  = 24;
  localparam int EKF_CUR_W   = 5;
  localparam int EKF_TMO_CYC = 4096;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    RDWAIT,
    LAUNCH,
    WAIT_CORE,
    UPDATE
  } ekf_state_t;

endpackage

// File: rtl/ekf_tmo_cnt.sv
// rtl/ekf_tmo_cnt.sv - loadable core-timeout counter with expire flag
module ekf_tmo_cnt
  import ekf_pkg::*;
#(
  parameter int TMO_CYC = EKF_TMO_CYC
) (
  input  logic clk,
  input  logic n_rst,
  input  logic load,
  input  logic inc,
  output logic expire
);

  localparam int CNT_W = (TMO_CYC > 2) ? $clog2(TMO_CYC) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TMO_CYC - 1);

  logic [CNT_W-1:0] cnt;

  // Saturates at LAST so a stalled count never wraps back to a live value.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (inc && !expire) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expire = (cnt == LAST);

endmodule

// File: rtl/ekf_sched.sv
// rtl/ekf_sched.sv - EKF SOC sequencer: fetch sample, launch core, capture result, advance
module ekf_sched
  import ekf_pkg::*;
#(
  parameter int N_SAMPLES = 1000,
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = EKF_DATA_W,
  parameter int CUR_W     = EKF_CUR_W,
  parameter int TMO_CYC   = EKF_TMO_CYC
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic              mode,
  input  logic              stop_top,
  output logic              smp_rd_en,
  output logic [ADDR_W-1:0] smp_addr,
  input  logic [DATA_W-1:0] smp_vt,
  input  logic [CUR_W-1:0]  smp_ib,
  output logic              core_start,
  output logic [DATA_W-1:0] core_vt,
  output logic [CUR_W-1:0]  core_ib,
  input  logic              core_done,
  input  logic [DATA_W-1:0] core_soc,
  input  logic [DATA_W-1:0] core_vrc,
  output logic [DATA_W-1:0] ekf_soc,
  output logic [DATA_W-1:0] ekf_vrc,
  output logic              ekf_done,
  output logic              busy,
  output logic              run_done,
  output logic              err_tmo,
  output logic [ADDR_W-1:0] sample_idx
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_SAMPLES - 1);

  ekf_state_t state;
  logic       mode_q;
  logic       stop_pend;
  logic       tmo_load;
  logic       tmo_inc;
  logic       tmo_expire;

  // Counter reads 0 during LAUNCH, so it equals cycles elapsed since core_start.
  assign tmo_load = (state == RDWAIT);
  assign tmo_inc  = (state == LAUNCH) || (state == WAIT_CORE);

  ekf_tmo_cnt #(.TMO_CYC(TMO_CYC)) u_tmo (
    .clk    (clk),
    .n_rst  (n_rst),
    .load   (tmo_load),
    .inc    (tmo_inc),
    .expire (tmo_expire)
  );

  always_ff @(posedge clk) begin
    if (n_rst) begin
      state      <= IDLE;
      mode_q     <= 1'b0;
      stop_pend  <= 1'b0;
      sample_idx <= '0;
      smp_rd_en  <= 1'b0;
      smp_addr   <= '0;
      core_start <= 1'b0;
      core_vt    <= '0;
      core_ib    <= '0;
      ekf_soc    <= '0;
      ekf_vrc    <= '0;
      ekf_done   <= 1'b0;
      busy       <= 1'b0;
      run_done   <= 1'b0;
      err_tmo    <= 1'b0;
    end else begin
      smp_rd_en  <= 1'b0;
      core_start <= 1'b0;
      ekf_done   <= 1'b0;
      run_done   <= 1'b0;
      if (stop_top && state != IDLE) begin
        stop_pend <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (start) begin
            mode_q    <= mode;
            err_tmo   <= 1'b0;
            smp_rd_en <= 1'b1;
            smp_addr  <= sample_idx;
            busy      <= 1'b1;
            state     <= FETCH;
          end
        end
        FETCH: begin
          state <= RDWAIT;
        end
        RDWAIT: begin
          core_vt    <= smp_vt;
          core_ib    <= smp_ib;
          core_start <= 1'b1;
          state      <= LAUNCH;
        end
        LAUNCH: begin
          state <= WAIT_CORE;
        end
        WAIT_CORE: begin
          if (core_done) begin
            ekf_soc  <= core_soc;
            ekf_vrc  <= core_vrc;
            ekf_done <= 1'b1;
            run_done <= (sample_idx == LAST_IDX);
            state    <= UPDATE;
          end else if (tmo_expire) begin
            err_tmo   <= 1'b1;
            stop_pend <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        UPDATE: begin
          stop_pend <= 1'b0;
          if (sample_idx == LAST_IDX) begin
            sample_idx <= '0;
            busy       <= 1'b0;
            state      <= IDLE;
          end else begin
            sample_idx <= sample_idx + ADDR_W'(1);
            // A stop arriving in this very cycle still halts after this result.
            if (!mode_q && !stop_pend && !stop_top) begin
              smp_rd_en <= 1'b1;
              smp_addr  <= sample_idx + ADDR_W'(1);
              state     <= FETCH;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ekf_sched.sv
// tb/tb_ekf_sched.sv - self-checking bench for ekf_sched
module tb_ekf_sched;
  import ekf_pkg::*;

  localparam int N   = 4;
  localparam int AW  = 10;
  localparam int TMO = 64;
  localparam int DW  = EKF_DATA_W;
  localparam int CW  = EKF_CUR_W;

  typedef struct {
    int exp_addr;
    int exp_idx;
    int exp_run;
  } vec_t;

  logic          clk = 1'b0;
  logic          n_rst, start, mode, stop_top;
  logic          smp_rd_en;
  logic [AW-1:0] smp_addr;
  logic [DW-1:0] smp_vt;
  logic [CW-1:0] smp_ib;
  logic          core_start;
  logic [DW-1:0] core_vt;
  logic [CW-1:0] core_ib;
  logic          core_done = 1'b0;
  logic [DW-1:0] core_soc = '0;
  logic [DW-1:0] core_vrc = '0;
  logic [DW-1:0] ekf_soc, ekf_vrc;
  logic          ekf_done, busy, run_done, err_tmo;
  logic [AW-1:0] sample_idx;

  ekf_sched #(
    .N_SAMPLES(N), .ADDR_W(AW), .DATA_W(DW), .CUR_W(CW), .TMO_CYC(TMO)
  ) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .mode(mode), .stop_top(stop_top),
    .smp_rd_en(smp_rd_en), .smp_addr(smp_addr), .smp_vt(smp_vt), .smp_ib(smp_ib),
    .core_start(core_start), .core_vt(core_vt), .core_ib(core_ib),
    .core_done(core_done), .core_soc(core_soc), .core_vrc(core_vrc),
    .ekf_soc(ekf_soc), .ekf_vrc(ekf_vrc), .ekf_done(ekf_done), .busy(busy),
    .run_done(run_done), .err_tmo(err_tmo), .sample_idx(sample_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Sample memory: one-cycle read latency, garbage when not reading.
  logic [DW-1:0] mem_vt [N];
  logic [CW-1:0] mem_ib [N];
  always @(posedge clk) begin
    if (smp_rd_en) begin
      smp_vt <= mem_vt[smp_addr[1:0]];
      smp_ib <= mem_ib[smp_addr[1:0]];
    end else begin
      smp_vt <= DW'($urandom);
      smp_ib <= CW'($urandom);
    end
  end

  function automatic logic [DW-1:0] f_soc(input logic [DW-1:0] vt, input logic [CW-1:0] ib);
    return vt ^ 24'h5A5A5A ^ {{(DW-CW){1'b0}}, ib};
  endfunction

  function automatic logic [DW-1:0] f_vrc(input logic [DW-1:0] vt, input logic [CW-1:0] ib);
    return vt + {ib, {(DW-CW){1'b0}}};
  endfunction

  // Core model: answers core_delay cycles after core_start (0 = never).
  int            core_delay = 20;
  bit            rnd_delay = 1'b0;
  bit            pend = 1'b0;
  int            done_at = 0;
  logic [DW-1:0] lat_vt;
  logic [CW-1:0] lat_ib;
  always @(negedge clk) begin
    core_done = 1'b0;
    if (pend && cyc == done_at) begin
      core_done = 1'b1;
      core_soc  = f_soc(lat_vt, lat_ib);
      core_vrc  = f_vrc(lat_vt, lat_ib);
      pend      = 1'b0;
    end
    if (core_start && core_delay != 0) begin
      pend    = 1'b1;
      lat_vt  = core_vt;
      lat_ib  = core_ib;
      done_at = cyc + (rnd_delay ? int'($urandom_range(1, 12)) : core_delay);
    end
  end

  int rd_q[$], cs_q[$], ed_q[$], soc_q[$], vrc_q[$];
  int run_cnt = 0;
  always @(negedge clk) begin
    if (smp_rd_en) rd_q.push_back(int'(smp_addr));
    if (core_start) cs_q.push_back(cyc);
    if (ekf_done) begin
      ed_q.push_back(cyc);
      soc_q.push_back(int'(ekf_soc));
      vrc_q.push_back(int'(ekf_vrc));
    end
    if (run_done) run_cnt++;
  end

  int vectors = 0;
  int miscompares = 0;
  int st_cyc = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic clear_logs();
    @(posedge clk);
    rd_q.delete(); cs_q.delete(); ed_q.delete(); soc_q.delete(); vrc_q.delete();
    run_cnt = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); n_rst = 1'b1;
    @(negedge clk); n_rst = 1'b0;
  endtask

  task automatic pulse_start(input logic m, input logic with_stop);
    @(negedge clk); start = 1'b1; mode = m; stop_top = with_stop; st_cyc = cyc;
    @(negedge clk); start = 1'b0; mode = ~m; stop_top = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    @(negedge clk);
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({name, " idle"}, busy, 0);
  endtask

  task automatic wait_cs(input string name, output int at);
    int n = 0;
    while (!core_start && n < 200) begin
      @(negedge clk);
      n++;
    end
    at = cyc;
    chk({name, " core_start seen"}, core_start, 1);
  endtask

  function automatic logic outs_nonzero();
    return |{smp_rd_en, smp_addr, core_start, core_vt, core_ib, ekf_soc, ekf_vrc,
             ekf_done, busy, run_done, err_tmo, sample_idx};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tab [5];
    int   at, at2, n, stop_off, m_idx;
    logic m;
    bit   stop_seen, halt;

    n_rst = 1'b1; start = 1'b0; mode = 1'b0; stop_top = 1'b0;
    for (int i = 0; i < N; i++) begin
      mem_vt[i] = DW'($urandom);
      mem_ib[i] = CW'($urandom);
    end
    tab[0] = '{0, 1, 0};
    tab[1] = '{1, 2, 0};
    tab[2] = '{2, 3, 0};
    tab[3] = '{3, 0, 1};
    tab[4] = '{0, 1, 0};

    repeat (3) @(negedge clk);
    n_rst = 1'b0;
    @(negedge clk);
    chk("reset outputs zero", outs_nonzero(), 0);

    // Single-step table
    core_delay = 7;
    for (int v = 0; v < 5; v++) begin
      clear_logs();
      pulse_start(1'b1, 1'b0);
      wait_idle("step", 100);
      chk("step reads", rd_q.size(), 1);
      chk("step addr", qat(rd_q, 0), tab[v].exp_addr);
      chk("step start->core_start", qat(cs_q, 0) - st_cyc, 3);
      chk("step core_start->ekf_done", qat(ed_q, 0) - qat(cs_q, 0), 8);
      chk("step soc", qat(soc_q, 0), f_soc(mem_vt[tab[v].exp_addr], mem_ib[tab[v].exp_addr]));
      chk("step vrc", qat(vrc_q, 0), f_vrc(mem_vt[tab[v].exp_addr], mem_ib[tab[v].exp_addr]));
      chk("step sample_idx", sample_idx, tab[v].exp_idx);
      chk("step run_done", run_cnt, tab[v].exp_run);
    end

    // Continuous run over all samples
    do_reset();
    chk("reset2 outputs zero", outs_nonzero(), 0);
    core_delay = 20;
    clear_logs();
    pulse_start(1'b0, 1'b0);
    wait_idle("cont", 400);
    chk("cont ekf_done count", ed_q.size(), 4);
    for (int i = 0; i < N; i++) begin
      chk("cont addr", qat(rd_q, i), i);
      chk("cont soc", qat(soc_q, i), f_soc(mem_vt[i], mem_ib[i]));
    end
    chk("cont run_done", run_cnt, 1);
    chk("cont sample_idx", sample_idx, 0);
    chk("cont ekf_done->core_start", qat(cs_q, 1) - qat(ed_q, 0), 3);

    // Stop 5 cycles after the second launch, then resume
    clear_logs();
    pulse_start(1'b0, 1'b0);
    wait_cs("stop", at);
    @(negedge clk);
    wait_cs("stop", at2);
    repeat (5) @(negedge clk);
    stop_top = 1'b1;
    @(negedge clk);
    stop_top = 1'b0;
    wait_idle("stop", 200);
    chk("stop ekf_done count", ed_q.size(), 2);
    chk("stop sample_idx", sample_idx, 2);
    chk("stop soc", ekf_soc, f_soc(mem_vt[1], mem_ib[1]));
    chk("stop run_done", run_cnt, 0);
    clear_logs();
    pulse_start(1'b1, 1'b0);
    wait_idle("resume", 100);
    chk("resume addr", qat(rd_q, 0), 2);
    chk("resume sample_idx", sample_idx, 3);

    // stop_top coincident with core_done, starts while busy
    do_reset();
    clear_logs();
    pulse_start(1'b0, 1'b0);
    wait_cs("coinc", at);
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    stop_top = 1'b1;
    start = 1'b1;
    @(negedge clk);
    stop_top = 1'b0;
    @(negedge clk);
    start = 1'b0;
    wait_idle("coinc", 100);
    chk("coinc core_start count", cs_q.size(), 1);
    chk("coinc ekf_done count", ed_q.size(), 1);
    chk("coinc sample_idx", sample_idx, 1);
    chk("coinc soc", ekf_soc, f_soc(mem_vt[0], mem_ib[0]));
    clear_logs();
    pulse_start(1'b0, 1'b0);
    wait_idle("coinc resume", 400);
    chk("coinc resume ekf_done count", ed_q.size(), 3);
    chk("coinc resume run_done", run_cnt, 1);
    chk("coinc resume sample_idx", sample_idx, 0);

    // Core timeout
    core_delay = 0;
    clear_logs();
    pulse_start(1'b0, 1'b0);
    wait_cs("tmo", at);
    n = 0;
    while (!err_tmo && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("tmo latency", cyc - at, 64);
    chk("tmo busy", busy, 0);
    chk("tmo sample_idx", sample_idx, 0);
    chk("tmo ekf_done count", ed_q.size(), 0);
    chk("tmo soc held", ekf_soc, f_soc(mem_vt[3], mem_ib[3]));
    repeat (5) @(negedge clk);
    chk("tmo sticky", err_tmo, 1);
    core_delay = 5;
    pulse_start(1'b1, 1'b0);
    chk("tmo cleared by start", err_tmo, 0);
    wait_idle("tmo retry", 100);
    chk("tmo retry sample_idx", sample_idx, 1);
    chk("tmo retry soc", ekf_soc, f_soc(mem_vt[0], mem_ib[0]));

    // Reset while waiting on the core; late core_done must be ignored
    core_delay = 20;
    clear_logs();
    pulse_start(1'b0, 1'b0);
    wait_cs("rst", at);
    repeat (5) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    n_rst = 1'b0;
    chk("rst outputs zero", outs_nonzero(), 0);
    repeat (30) @(negedge clk);
    chk("rst late done ignored", ed_q.size(), 0);
    chk("rst busy", busy, 0);
    chk("rst soc", ekf_soc, 0);
    chk("rst sample_idx", sample_idx, 0);

    // Randomized runs against an iteration-level model
    rnd_delay = 1'b1;
    m_idx = 0;
    for (int r = 0; r < 40; r++) begin
      m = 1'($urandom_range(0, 1));
      stop_off = $urandom_range(0, 80);
      stop_seen = 1'b0;
      halt = 1'b0;
      pulse_start(m, stop_off == 0);
      n = 1;
      while (n < 600) begin
        stop_top = (n == stop_off);
        if (stop_top && busy) stop_seen = 1'b1;
        if (ekf_done) begin
          if (halt) chk("rnd extra iteration", 1, 0);
          chk("rnd soc", ekf_soc, f_soc(mem_vt[m_idx], mem_ib[m_idx]));
          chk("rnd vrc", ekf_vrc, f_vrc(mem_vt[m_idx], mem_ib[m_idx]));
          chk("rnd run_done", run_done, (m_idx == N - 1) ? 1 : 0);
          halt = (m == 1'b1) || (m_idx == N - 1) || stop_seen;
          m_idx = (m_idx + 1) % N;
        end
        if (!busy) break;
        @(negedge clk);
        n++;
      end
      stop_top = 1'b0;
      chk("rnd halted", busy, 0);
      chk("rnd halt predicted", halt, 1);
      chk("rnd sample_idx", sample_idx, m_idx);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
